// File: rtl/bus_drive_decoder_if.sv
// Handshake and bus out-enable bundle between the control unit (master) and
// the bus drive decoder (slave).
interface bus_drive_decoder_if #(
    parameter int SEL_W = 5
);
    logic             sel_valid;
    logic [SEL_W-1:0] sel;
    logic             sel_ready;
    logic [15:0]      RoutSignals;
    logic             HIout;
    logic             LOout;
    logic             Yout;
    logic             Zhighout;
    logic             Zlowout;
    logic             PCout;
    logic             MDRout;
    logic             InPortout;
    logic             Cout;
    logic             bus_idle;
    logic             sel_err;
    logic [15:0]      drive_count;

    modport master (
        output sel_valid, sel,
        input  sel_ready, RoutSignals, HIout, LOout, Yout, Zhighout, Zlowout,
               PCout, MDRout, InPortout, Cout, bus_idle, sel_err, drive_count
    );

    modport slave (
        input  sel_valid, sel,
        output sel_ready, RoutSignals, HIout, LOout, Yout, Zhighout, Zlowout,
               PCout, MDRout, InPortout, Cout, bus_idle, sel_err, drive_count
    );
endinterface

// File: rtl/bus_drive_decoder.sv
// Registered source-code to one-hot bus out-enable decoder with break-before-make.
// Optional feature macro: BUS_DRIVE_STATS_EN (source-switch counter).
module bus_drive_decoder #(
    parameter int NUM_SRC  = 25,
    parameter int SEL_W    = 5,
    parameter int TURN_CYC = 1
) (
    input  logic                 clock,
    input  logic                 clear,
    bus_drive_decoder_if.slave   bus
);
    localparam int NUM_OUT = 25;
    localparam int CNT_W   = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
    localparam logic [CNT_W-1:0] TURN_LD = (TURN_CYC > 0) ? CNT_W'(TURN_CYC - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    state_t               state_r, state_s;
    logic [SEL_W-1:0]     cur_r, cur_s;
    logic [SEL_W-1:0]     pend_r, pend_s;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic [NUM_SRC-1:0]   en_r, en_s;
    logic                 idle_r;
    logic                 ready_r, ready_s;
    logic                 err_r, err_s;
    logic                 sel_ok_s;
    logic                 sel_bad_s;
    logic [NUM_OUT-1:0]   out_s;

    function automatic logic [NUM_SRC-1:0] onehot_f(input logic [SEL_W-1:0] code);
        logic [NUM_SRC-1:0] v;
        v       = '0;
        v[code] = 1'b1;
        return v;
    endfunction

    // Classify the incoming request as a drivable source or an out-of-range code.
    always_comb begin
        sel_ok_s  = bus.sel_valid && (32'(bus.sel) <  32'(NUM_SRC));
        sel_bad_s = bus.sel_valid && (32'(bus.sel) >= 32'(NUM_SRC));
    end

    // Next-state and next-output logic; every output is computed here and registered below.
    always_comb begin
        state_s = state_r;
        cur_s   = cur_r;
        pend_s  = pend_r;
        cnt_s   = cnt_r;
        en_s    = '0;
        ready_s = 1'b1;
        err_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (sel_ok_s) begin
                    state_s = ST_DRIVE;
                    cur_s   = bus.sel;
                    en_s    = onehot_f(bus.sel);
                end else if (sel_bad_s) begin
                    err_s   = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (sel_ok_s && (bus.sel == cur_r)) begin
                    en_s = onehot_f(cur_r);
                end else if (sel_ok_s) begin
                    // A change of source either opens a dead-bus gap or swaps directly.
                    if (TURN_CYC > 0) begin
                        state_s = ST_TURN;
                        pend_s  = bus.sel;
                        cnt_s   = TURN_LD;
                        ready_s = 1'b0;
                    end else begin
                        cur_s   = bus.sel;
                        en_s    = onehot_f(bus.sel);
                    end
                end else if (sel_bad_s) begin
                    state_s = ST_IDLE;
                    err_s   = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_TURN: begin
                if (cnt_r == '0) begin
                    state_s = ST_DRIVE;
                    cur_s   = pend_r;
                    en_s    = onehot_f(pend_r);
                end else begin
                    cnt_s   = cnt_r - CNT_W'(1);
                    ready_s = 1'b0;
                end
            end
            default: begin
                state_s = ST_IDLE;
                en_s    = '0;
            end
        endcase
    end

    // State and registered outputs; clear drops every enable immediately.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_r <= ST_IDLE;
            cur_r   <= '0;
            pend_r  <= '0;
            cnt_r   <= '0;
            en_r    <= '0;
            idle_r  <= 1'b1;
            ready_r <= 1'b1;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cur_r   <= cur_s;
            pend_r  <= pend_s;
            cnt_r   <= cnt_s;
            en_r    <= en_s;
            idle_r  <= ~|en_s;
            ready_r <= ready_s;
            err_r   <= err_s;
        end
    end

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_out
        if (i < NUM_SRC) begin : g_used
            assign out_s[i] = en_r[i];
        end else begin : g_unused
            assign out_s[i] = 1'b0;
        end
    end

    assign bus.RoutSignals = out_s[15:0];
    assign bus.HIout       = out_s[16];
    assign bus.LOout       = out_s[17];
    assign bus.Yout        = out_s[18];
    assign bus.Zhighout    = out_s[19];
    assign bus.Zlowout     = out_s[20];
    assign bus.PCout       = out_s[21];
    assign bus.MDRout      = out_s[22];
    assign bus.InPortout   = out_s[23];
    assign bus.Cout        = out_s[24];
    assign bus.bus_idle    = idle_r;
    assign bus.sel_ready   = ready_r;
    assign bus.sel_err     = err_r;

`ifdef BUS_DRIVE_STATS_EN
    logic        enter_drive_s;
    logic [15:0] drive_count_r;

    // A switch is counted whenever the next cycle drives a source not driven now.
    assign enter_drive_s = (state_s == ST_DRIVE) &&
                           ((state_r != ST_DRIVE) || (cur_s != cur_r));

    // Saturating source-switch counter.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            drive_count_r <= 16'h0000;
        end else if (enter_drive_s && (drive_count_r != 16'hFFFF)) begin
            drive_count_r <= drive_count_r + 16'h0001;
        end else begin
            drive_count_r <= drive_count_r;
        end
    end

    assign bus.drive_count = drive_count_r;
`else
    assign bus.drive_count = 16'h0000;
`endif

endmodule

// File: tb/tb_bus_drive_decoder.sv
// Scoreboard bench for bus_drive_decoder: one instance with a one-cycle turn
// gap and one with direct switching, driven by directed vectors.
module tb_bus_drive_decoder;

    typedef struct {
        bit          d;
        logic [24:0] en;
        logic        idle;
        logic        ready;
        logic        err;
        bit          cc;
        logic [15:0] cnt;
        string       name;
    } exp_t;

`ifdef BUS_DRIVE_STATS_EN
    localparam logic [15:0] EXP_CNT5 = 16'd3;
    localparam logic [15:0] EXP_CNT6 = 16'd4;
`else
    localparam logic [15:0] EXP_CNT5 = 16'd0;
    localparam logic [15:0] EXP_CNT6 = 16'd0;
`endif

    logic clock;
    logic clear;
    int   n_cmp;
    int   n_fail;
    exp_t exp_q[$];
    exp_t m_e;

    bus_drive_decoder_if #(.SEL_W(5)) if1 ();
    bus_drive_decoder_if #(.SEL_W(5)) if0 ();

    bus_drive_decoder #(.NUM_SRC(25), .SEL_W(5), .TURN_CYC(1)) dut1 (
        .clock (clock),
        .clear (clear),
        .bus   (if1.slave)
    );

    bus_drive_decoder #(.NUM_SRC(25), .SEL_W(5), .TURN_CYC(0)) dut0 (
        .clock (clock),
        .clear (clear),
        .bus   (if0.slave)
    );

    logic [24:0] act_en1, act_en0;
    assign act_en1 = {if1.Cout, if1.InPortout, if1.MDRout, if1.PCout, if1.Zlowout,
                      if1.Zhighout, if1.Yout, if1.LOout, if1.HIout, if1.RoutSignals};
    assign act_en0 = {if0.Cout, if0.InPortout, if0.MDRout, if0.PCout, if0.Zlowout,
                      if0.Zhighout, if0.Yout, if0.LOout, if0.HIout, if0.RoutSignals};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [24:0] oh(input int c);
        logic [24:0] v;
        v    = 25'd0;
        v[c] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic step(input string nm, input bit d, input bit v, input logic [4:0] s,
                        input logic [24:0] een, input bit erdy, input bit eerr,
                        input bit cc = 1'b0, input logic [15:0] ec = 16'h0000);
        exp_t e;
        #1;
        if (d) begin
            if1.sel_valid = v;
            if1.sel       = s;
        end else begin
            if0.sel_valid = v;
            if0.sel       = s;
        end
        e.d     = d;
        e.en    = een;
        e.idle  = (een == 25'd0);
        e.ready = erdy;
        e.err   = eerr;
        e.cc    = cc;
        e.cnt   = ec;
        e.name  = nm;
        exp_q.push_back(e);
        @(negedge clock);
    endtask

    // Scoreboard monitor: pops one expectation per cycle in which one is queued.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            m_e = exp_q.pop_front();
            if (m_e.d) begin
                chk({m_e.name, "_en"},    {7'd0, act_en1},        {7'd0, m_e.en});
                chk({m_e.name, "_idle"},  {31'd0, if1.bus_idle},  {31'd0, m_e.idle});
                chk({m_e.name, "_ready"}, {31'd0, if1.sel_ready}, {31'd0, m_e.ready});
                chk({m_e.name, "_err"},   {31'd0, if1.sel_err},   {31'd0, m_e.err});
                if (m_e.cc) chk({m_e.name, "_cnt"}, {16'd0, if1.drive_count}, {16'd0, m_e.cnt});
            end else begin
                chk({m_e.name, "_en"},    {7'd0, act_en0},        {7'd0, m_e.en});
                chk({m_e.name, "_idle"},  {31'd0, if0.bus_idle},  {31'd0, m_e.idle});
                chk({m_e.name, "_ready"}, {31'd0, if0.sel_ready}, {31'd0, m_e.ready});
                chk({m_e.name, "_err"},   {31'd0, if0.sel_err},   {31'd0, m_e.err});
                if (m_e.cc) chk({m_e.name, "_cnt"}, {16'd0, if0.drive_count}, {16'd0, m_e.cnt});
            end
        end
    end

    // Every cycle: never two drivers, and bus_idle agrees with the enables.
    always @(negedge clock) begin
        chk("onehot1", {31'd0, ($countones(act_en1) <= 1)}, 32'd1);
        chk("onehot0", {31'd0, ($countones(act_en0) <= 1)}, 32'd1);
        chk("idle_cons1", {31'd0, if1.bus_idle}, {31'd0, (act_en1 == 25'd0)});
        chk("idle_cons0", {31'd0, if0.bus_idle}, {31'd0, (act_en0 == 25'd0)});
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        clear  = 1'b1;
        if1.sel_valid = 1'b0; if1.sel = 5'd0;
        if0.sel_valid = 1'b0; if0.sel = 5'd0;
        #1;
        chk("rst_en",    {7'd0, act_en1},          32'd0);
        chk("rst_idle",  {31'd0, if1.bus_idle},    32'd1);
        chk("rst_ready", {31'd0, if1.sel_ready},   32'd1);
        chk("rst_err",   {31'd0, if1.sel_err},     32'd0);
        chk("rst_cnt",   {16'd0, if1.drive_count}, 32'd0);
        chk("rst_en0",   {7'd0, act_en0},          32'd0);
        @(negedge clock);
        clear = 1'b0;

        // 1: PC driven one cycle after request
        step("t1_pc",    1, 1'b1, 5'd21, oh(21), 1'b1, 1'b0);
        step("t2_rel",   1, 1'b0, 5'd0,  25'd0,  1'b1, 1'b0);
        // 2: R3 -> MDR through one dead-bus cycle
        step("t2_r3",    1, 1'b1, 5'd3,  oh(3),  1'b1, 1'b0);
        step("t2_r3h",   1, 1'b1, 5'd3,  oh(3),  1'b1, 1'b0);
        step("t2_turn",  1, 1'b1, 5'd22, 25'd0,  1'b0, 1'b0);
        step("t2_mdr",   1, 1'b1, 5'd22, oh(22), 1'b1, 1'b0);
        step("t2_mdrh",  1, 1'b1, 5'd22, oh(22), 1'b1, 1'b0);
        step("t2_turn5", 1, 1'b1, 5'd5,  25'd0,  1'b0, 1'b0);
        step("t2_ign",   1, 1'b0, 5'd0,  oh(5),  1'b1, 1'b0);
        step("t2_rel2",  1, 1'b0, 5'd0,  25'd0,  1'b1, 1'b0);
        // 3: out-of-range codes from IDLE and from DRIVE
        step("t3_bad30", 1, 1'b1, 5'd30, 25'd0,  1'b1, 1'b1);
        step("t3_clr",   1, 1'b0, 5'd0,  25'd0,  1'b1, 1'b0);
        step("t3_r7",    1, 1'b1, 5'd7,  oh(7),  1'b1, 1'b0);
        step("t3_bad25", 1, 1'b1, 5'd25, 25'd0,  1'b1, 1'b1);
        step("t3_c24",   1, 1'b1, 5'd24, oh(24), 1'b1, 1'b0);
        step("t3_rel",   1, 1'b0, 5'd0,  25'd0,  1'b1, 1'b0);
        // 4: clear mid-TURN, then clear while driving
        step("t4_z19",   1, 1'b1, 5'd19, oh(19), 1'b1, 1'b0);
        step("t4_turn",  1, 1'b1, 5'd2,  25'd0,  1'b0, 1'b0);
        #2;
        clear = 1'b1;
        if1.sel_valid = 1'b0;
        #1;
        chk("t4_clr_en",    {7'd0, act_en1},          32'd0);
        chk("t4_clr_ready", {31'd0, if1.sel_ready},   32'd1);
        chk("t4_clr_cnt",   {16'd0, if1.drive_count}, 32'd0);
        @(negedge clock);
        clear = 1'b0;
        step("t4_idle_a", 1, 1'b0, 5'd0, 25'd0, 1'b1, 1'b0);
        step("t4_idle_b", 1, 1'b0, 5'd0, 25'd0, 1'b1, 1'b0, 1'b1, 16'd0);
        step("t4_r9",     1, 1'b1, 5'd9, oh(9), 1'b1, 1'b0);
        #2;
        clear = 1'b1;
        if1.sel_valid = 1'b0;
        #1;
        chk("t4_async_en",   {7'd0, act_en1},       32'd0);
        chk("t4_async_idle", {31'd0, if1.bus_idle}, 32'd1);
        @(negedge clock);
        clear = 1'b0;
        step("t4_idle_c", 1, 1'b0, 5'd0, 25'd0, 1'b1, 1'b0);
        // 5: direct swap R5 -> R6 -> R5 with no turn gap
        step("t5_r5",   0, 1'b1, 5'd5, oh(5), 1'b1, 1'b0);
        step("t5_r6",   0, 1'b1, 5'd6, oh(6), 1'b1, 1'b0);
        step("t5_r5b",  0, 1'b1, 5'd5, oh(5), 1'b1, 1'b0);
        step("t5_hold", 0, 1'b1, 5'd5, oh(5), 1'b1, 1'b0, 1'b1, EXP_CNT5);
        step("t5_rel",  0, 1'b0, 5'd0, 25'd0, 1'b1, 1'b0);
        // 6: 0 -> 16 -> 17 -> IDLE -> 24
        step("t6_r0",    1, 1'b1, 5'd0,  oh(0),  1'b1, 1'b0);
        step("t6_turn1", 1, 1'b1, 5'd16, 25'd0,  1'b0, 1'b0);
        step("t6_hi",    1, 1'b1, 5'd16, oh(16), 1'b1, 1'b0);
        step("t6_turn2", 1, 1'b1, 5'd17, 25'd0,  1'b0, 1'b0);
        step("t6_lo",    1, 1'b1, 5'd17, oh(17), 1'b1, 1'b0);
        step("t6_idle",  1, 1'b0, 5'd0,  25'd0,  1'b1, 1'b0);
        step("t6_c",     1, 1'b1, 5'd24, oh(24), 1'b1, 1'b0, 1'b1, EXP_CNT6);
        step("t6_rel",   1, 1'b0, 5'd0,  25'd0,  1'b1, 1'b0, 1'b1, EXP_CNT6);

        @(negedge clock);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
